// File: rtl/sim_run_driver.sv
// sim_run_driver: host-command front end for the network simulation datapath.
// Buffers an inhibitor list and initial state, then per RUN resets the
// datapath, replays the inhibitor loads, pulses start and waits for either a
// steady state or the iteration limit before returning the result.
// Optional build macro: SIM_RUN_DRIVER_TRACE_EN adds a state-change trace port.
module sim_run_driver #(
  parameter int STATE_W   = 32,
  parameter int LOG_RULES = 5,
  parameter int MAX_INHIB = 8,
  parameter int ITER_W    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [STATE_W-1:0]   cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [STATE_W-1:0]   rsp_state,
  output logic [ITER_W-1:0]    rsp_iter,
  output logic                 rsp_steady,
  output logic                 inh_ovf,
  output logic                 sim_rst,
  output logic                 start,
  output logic                 ld_inhibitor,
  output logic [LOG_RULES-1:0] sel_inhibitor,
  output logic [STATE_W-1:0]   initial_state,
  input  logic [STATE_W-1:0]   network_state,
  input  logic                 steady_state,
  input  logic [ITER_W-1:0]    iteration_number
`ifdef SIM_RUN_DRIVER_TRACE_EN
  ,
  output logic                 trace_valid,
  output logic [STATE_W-1:0]   trace_state,
  output logic [ITER_W-1:0]    trace_iter
`endif
);

  localparam int CNT_W = $clog2(MAX_INHIB + 1);
  localparam int IDX_W = (MAX_INHIB > 1) ? $clog2(MAX_INHIB) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INHIB);

  localparam logic [1:0] OP_CLEAR    = 2'd0;
  localparam logic [1:0] OP_ADD_INH  = 2'd1;
  localparam logic [1:0] OP_SET_INIT = 2'd2;
  localparam logic [1:0] OP_RUN      = 2'd3;

  typedef enum logic [2:0] {IDLE, SRST, LOAD, STRT, WAIT, RESP} state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     load_idx;
  logic [LOG_RULES-1:0] list [MAX_INHIB];
  logic [ITER_W-1:0]    limit;
  logic                 first_wait;
  logic                 cmd_fire;
  logic                 steady_hit;
  logic                 limit_hit;
  logic                 done;

  assign cmd_fire   = cmd_valid && (state == IDLE);
  // The first WAIT cycle can still see a steady flag left over from the previous run
  assign steady_hit = steady_state && !first_wait;
  assign limit_hit  = (limit != '0) && (iteration_number >= limit);
  assign done       = (state == WAIT) && (steady_hit || limit_hit);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and per-state strobes; strobes come straight from the state so reset clears them at once
  always_comb begin
    state_next    = state;
    cmd_ready     = 1'b0;
    sim_rst       = 1'b0;
    start         = 1'b0;
    ld_inhibitor  = 1'b0;
    sel_inhibitor = '0;
    rsp_valid     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && cmd_op == OP_RUN) state_next = SRST;
      end
      SRST: begin
        sim_rst    = 1'b1;
        state_next = (count == '0) ? STRT : LOAD;
      end
      LOAD: begin
        ld_inhibitor  = 1'b1;
        sel_inhibitor = list[load_idx[IDX_W-1:0]];
        if (load_idx + CNT_W'(1) == count) state_next = STRT;
      end
      STRT: begin
        start      = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (done) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Host command effects on the buffered configuration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count         <= '0;
      inh_ovf       <= 1'b0;
      initial_state <= '0;
      limit         <= '0;
    end else if (cmd_fire) begin
      case (cmd_op)
        OP_CLEAR: begin
          count   <= '0;
          inh_ovf <= 1'b0;
        end
        OP_ADD_INH: begin
          if (count < MAX_CNT) count <= count + CNT_W'(1);
          else                 inh_ovf <= 1'b1;
        end
        OP_SET_INIT: initial_state <= cmd_data;
        default:     limit <= cmd_data[ITER_W-1:0];
      endcase
    end
  end

  // Inhibitor list storage; contents only matter below count so it needs no reset
  always_ff @(posedge clk) begin
    if (cmd_fire && cmd_op == OP_ADD_INH && count < MAX_CNT)
      list[count[IDX_W-1:0]] <= cmd_data[LOG_RULES-1:0];
  end

  // Replay pointer and first-WAIT-cycle marker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_idx   <= '0;
      first_wait <= 1'b0;
    end else begin
      first_wait <= (state == STRT);
      if (state == SRST)      load_idx <= '0;
      else if (state == LOAD) load_idx <= load_idx + CNT_W'(1);
    end
  end

  // Result capture in the terminating cycle; steady wins when both causes coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_state  <= '0;
      rsp_iter   <= '0;
      rsp_steady <= 1'b0;
    end else if (done) begin
      rsp_state  <= network_state;
      rsp_iter   <= iteration_number;
      rsp_steady <= steady_hit;
    end
  end

`ifdef SIM_RUN_DRIVER_TRACE_EN
  logic [STATE_W-1:0] prev_state;

  // Emit one trace beat per datapath state change while a run is in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_state  <= '0;
      trace_valid <= 1'b0;
      trace_state <= '0;
      trace_iter  <= '0;
    end else begin
      trace_valid <= 1'b0;
      if (state == STRT) begin
        prev_state <= initial_state;
      end else if (state == WAIT && network_state != prev_state) begin
        prev_state  <= network_state;
        trace_valid <= 1'b1;
        trace_state <= network_state;
        trace_iter  <= iteration_number;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sim_run_driver.sv
// Testbench for sim_run_driver: a behavioural datapath model answers start
// pulses, a scoreboard queue holds hand-computed responses, and a monitor
// pops and compares whenever a response handshake occurs.
module tb_sim_run_driver;

  localparam int STATE_W   = 32;
  localparam int LOG_RULES = 5;
  localparam int MAX_INHIB = 8;
  localparam int ITER_W    = 10;

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_ADD   = 2'd1;
  localparam logic [1:0] OP_SET   = 2'd2;
  localparam logic [1:0] OP_RUN   = 2'd3;

  logic                 clk;
  logic                 rst;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [STATE_W-1:0]   cmd_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [STATE_W-1:0]   rsp_state;
  logic [ITER_W-1:0]    rsp_iter;
  logic                 rsp_steady;
  logic                 inh_ovf;
  logic                 sim_rst;
  logic                 start;
  logic                 ld_inhibitor;
  logic [LOG_RULES-1:0] sel_inhibitor;
  logic [STATE_W-1:0]   initial_state;
  logic [STATE_W-1:0]   network_state;
  logic                 steady_state;
  logic [ITER_W-1:0]    iteration_number;
`ifdef SIM_RUN_DRIVER_TRACE_EN
  logic                 trace_valid;
  logic [STATE_W-1:0]   trace_state;
  logic [ITER_W-1:0]    trace_iter;
`endif

  typedef struct {
    logic [STATE_W-1:0] st;
    logic [ITER_W-1:0]  it;
    logic               sd;
  } rsp_t;

  rsp_t                 sb[$];
  logic [LOG_RULES-1:0] ld_log[$];
  logic [LOG_RULES-1:0] exp_sel[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int start_cyc = 0;
  int n_srst = 0;
  int n_start = 0;
  int n_overlap = 0;
  int n_trace = 0;

  logic start_q = 1'b0;
  logic srst_q = 1'b0;
  int   mdl_steady_at = 0;
  bit   mdl_stale = 1'b0;
  bit   mdl_running = 1'b0;
  bit   mdl_reached = 1'b0;
  int   mdl_iter = 0;

  sim_run_driver #(
    .STATE_W(STATE_W), .LOG_RULES(LOG_RULES), .MAX_INHIB(MAX_INHIB), .ITER_W(ITER_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_state(rsp_state),
    .rsp_iter(rsp_iter), .rsp_steady(rsp_steady), .inh_ovf(inh_ovf),
    .sim_rst(sim_rst), .start(start), .ld_inhibitor(ld_inhibitor),
    .sel_inhibitor(sel_inhibitor), .initial_state(initial_state),
    .network_state(network_state), .steady_state(steady_state),
    .iteration_number(iteration_number)
`ifdef SIM_RUN_DRIVER_TRACE_EN
    ,
    .trace_valid(trace_valid), .trace_state(trace_state), .trace_iter(trace_iter)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] data);
    int   n;
    logic rdy;
    n = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    do begin
      @(negedge clk);
      rdy = cmd_ready;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      checks++;
      errors++;
      $display("[TB] FAIL cmd_accept: cmd_ready stayed 0 for %0d cycles", n);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic clearLog();
    n_srst    = 0;
    n_start   = 0;
    n_overlap = 0;
    n_trace   = 0;
    acc_cyc   = 0;
    start_cyc = 0;
    ld_log.delete();
  endtask

  task automatic waitResponse(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: %0d responses outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic checkRun(input string name);
    checkOutput({name, "_srst_cycles"}, 64'(n_srst), 64'd1);
    checkOutput({name, "_start_cycles"}, 64'(n_start), 64'd1);
    checkOutput({name, "_ld_cycles"}, 64'(ld_log.size()), 64'(exp_sel.size()));
    for (int i = 0; i < exp_sel.size(); i++)
      if (i < ld_log.size())
        checkOutput($sformatf("%s_sel%0d", name, i), 64'(ld_log[i]), 64'(exp_sel[i]));
    checkOutput({name, "_start_latency"}, 64'(start_cyc - acc_cyc), 64'(2 + exp_sel.size()));
    checkOutput({name, "_ld_overlap"}, 64'(n_overlap), 64'd0);
  endtask

  task automatic checkIdleReset(input string name);
    checkOutput({name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    checkOutput({name, "_strobes"}, 64'({sim_rst, start, ld_inhibitor, rsp_valid}), 64'd0);
    checkOutput({name, "_sel"}, 64'(sel_inhibitor), 64'd0);
    checkOutput({name, "_inh_ovf"}, 64'(inh_ovf), 64'd0);
    checkOutput({name, "_initial_state"}, 64'(initial_state), 64'd0);
    checkOutput({name, "_rsp_fields"}, 64'({rsp_state, rsp_iter, rsp_steady}), 64'd0);
  endtask

  // Strobe monitor: logs datapath-side strobes once per cycle away from the active edge
  initial forever begin
    @(negedge clk);
    cyc++;
    start_q = start;
    srst_q  = sim_rst;
    if (cmd_valid && cmd_ready && cmd_op == OP_RUN) acc_cyc = cyc;
    if (sim_rst) n_srst++;
    if (start) begin
      n_start++;
      start_cyc = cyc;
    end
    if (ld_inhibitor) begin
      ld_log.push_back(sel_inhibitor);
      if (sim_rst || start) n_overlap++;
    end
`ifdef SIM_RUN_DRIVER_TRACE_EN
    if (trace_valid) n_trace++;
`endif
  end

  // Response monitor: pops the scoreboard on each handshake
  initial forever begin
    rsp_t e;
    @(negedge clk);
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: state 0x%0h with empty scoreboard, expected none", rsp_state);
      end else begin
        e = sb.pop_front();
        checkOutput("rsp_state", 64'(rsp_state), 64'(e.st));
        checkOutput("rsp_iter", 64'(rsp_iter), 64'(e.it));
        checkOutput("rsp_steady", 64'(rsp_steady), 64'(e.sd));
      end
    end
  end

  // Datapath model: one iteration per cycle after start, state = initial + iteration
  initial forever begin
    @(posedge clk);
    #1;
    if (srst_q) begin
      mdl_running      = 1'b0;
      mdl_reached      = 1'b0;
      mdl_iter         = 0;
      network_state    = '0;
      steady_state     = 1'b0;
      iteration_number = '0;
    end else if (start_q) begin
      mdl_running      = 1'b1;
      mdl_iter         = 1;
      mdl_reached      = (mdl_steady_at == 1);
      network_state    = initial_state + 32'd1;
      steady_state     = mdl_stale || mdl_reached;
      iteration_number = ITER_W'(mdl_iter);
    end else if (mdl_running && !mdl_reached) begin
      mdl_iter++;
      mdl_reached      = (mdl_steady_at != 0) && (mdl_iter == mdl_steady_at);
      network_state    = initial_state + 32'(mdl_iter);
      steady_state     = mdl_reached;
      iteration_number = ITER_W'(mdl_iter);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst              = 1'b1;
    cmd_valid        = 1'b0;
    cmd_op           = '0;
    cmd_data         = '0;
    rsp_ready        = 1'b1;
    network_state    = '0;
    steady_state     = 1'b0;
    iteration_number = '0;

    repeat (3) @(negedge clk);
    checkIdleReset("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // Two inhibitors, steady at iteration 4
    $display("[TB] run1: two inhibitors, steady at 4");
    applyStimulus(OP_ADD, 32'd3);
    applyStimulus(OP_ADD, 32'd7);
    applyStimulus(OP_SET, 32'h0000_00A5);
    checkOutput("set_init", 64'(initial_state), 64'h0000_00A5);
    clearLog();
    exp_sel       = '{5'd3, 5'd7};
    mdl_steady_at = 4;
    mdl_stale     = 1'b0;
    sb.push_back('{st: 32'h0000_00A9, it: 10'd4, sd: 1'b1});
    applyStimulus(OP_RUN, 32'd0);
    waitResponse("run1");
    repeat (2) @(negedge clk);
    checkRun("run1");
`ifdef SIM_RUN_DRIVER_TRACE_EN
    checkOutput("run1_trace_beats", 64'(n_trace), 64'd4);
`endif

    // Empty list, iteration limit 5, never steady
    $display("[TB] run2: cleared list, limit 5");
    applyStimulus(OP_CLEAR, 32'd0);
    clearLog();
    exp_sel.delete();
    mdl_steady_at = 0;
    sb.push_back('{st: 32'h0000_00AA, it: 10'd5, sd: 1'b0});
    applyStimulus(OP_RUN, 32'd5);
    waitResponse("run2");
    repeat (2) @(negedge clk);
    checkRun("run2");

    // Overflow: nine adds, eight kept
    $display("[TB] run3: list overflow");
    for (int i = 0; i < 8; i++) applyStimulus(OP_ADD, 32'(10 + i));
    checkOutput("ovf_after_8", 64'(inh_ovf), 64'd0);
    applyStimulus(OP_ADD, 32'd20);
    checkOutput("ovf_after_9", 64'(inh_ovf), 64'd1);
    clearLog();
    exp_sel = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17};
    mdl_steady_at = 2;
    sb.push_back('{st: 32'h0000_00A7, it: 10'd2, sd: 1'b1});
    applyStimulus(OP_RUN, 32'd0);
    waitResponse("run3");
    repeat (2) @(negedge clk);
    checkRun("run3");
    applyStimulus(OP_CLEAR, 32'd0);
    checkOutput("ovf_after_clear", 64'(inh_ovf), 64'd0);

    // Steady and limit coincide at 6; stale steady in first WAIT cycle
    $display("[TB] run4: steady and limit together, stale flag");
    applyStimulus(OP_SET, 32'h0000_1000);
    clearLog();
    exp_sel.delete();
    mdl_steady_at = 6;
    mdl_stale     = 1'b1;
    sb.push_back('{st: 32'h0000_1006, it: 10'd6, sd: 1'b1});
    applyStimulus(OP_RUN, 32'd6);
    waitResponse("run4");
    repeat (2) @(negedge clk);
    checkRun("run4");
    mdl_stale = 1'b0;

    // Response backpressure for 10 cycles
    $display("[TB] run5: response backpressure");
    rsp_ready = 1'b0;
    clearLog();
    mdl_steady_at = 3;
    sb.push_back('{st: 32'h0000_1003, it: 10'd3, sd: 1'b1});
    applyStimulus(OP_RUN, 32'd0);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("run5_rsp_valid_seen", 64'(rsp_valid), 64'd1);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_state !== 32'h0000_1003 ||
          rsp_iter !== 10'd3 || rsp_steady !== 1'b1) n++;
    end
    checkOutput("run5_hold_unstable_cycles", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("run5_idle_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("run5_rsp_valid_drop", 64'(rsp_valid), 64'd0);
    waitResponse("run5");
    checkRun("run5");

    // Asynchronous reset in the middle of WAIT
    $display("[TB] run6: reset mid-WAIT");
    for (int i = 0; i < 9; i++) applyStimulus(OP_ADD, 32'd1);
    clearLog();
    mdl_steady_at = 0;
    applyStimulus(OP_RUN, 32'd0);
    n = 0;
    while (n_start == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("run6_started", 64'(n_start), 64'd1);
    repeat (3) @(negedge clk);
    checkOutput("run6_busy_before_rst", 64'(cmd_ready), 64'd0);
    checkOutput("run6_ovf_before_rst", 64'(inh_ovf), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkIdleReset("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("after_reset_no_rsp", 64'(rsp_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
